block_mac_2x2: RTL and testbench

BLOCK_MAC_2X2 -- requirements
Module: block_mac_2x2

---
 rtl/block_mac_2x2.sv | 148 ++++++++++++++
 tb/tb_block_mac_2x2.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/block_mac_2x2.sv
// 2x2 block matrix multiply C = A x B using one time-shared signed multiplier, 8 cycles per block.
// Optional accumulate mode (C += A x B, with acc_clr to restart) is enabled by defining BLOCK_MAC_ACCUM_EN.
module block_mac_2x2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef BLOCK_MAC_ACCUM_EN
  input  logic              acc_clr,
`endif
  input  logic [DATA_W-1:0] a_11,
  input  logic [DATA_W-1:0] a_12,
  input  logic [DATA_W-1:0] a_21,
  input  logic [DATA_W-1:0] a_22,
  input  logic [DATA_W-1:0] b_11,
  input  logic [DATA_W-1:0] b_12,
  input  logic [DATA_W-1:0] b_21,
  input  logic [DATA_W-1:0] b_22,
  output logic [DATA_W-1:0] c_11,
  output logic [DATA_W-1:0] c_12,
  output logic [DATA_W-1:0] c_21,
  output logic [DATA_W-1:0] c_22,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         cnt;
  logic [DATA_W-1:0]  a_q [4];   // index {row, k}
  logic [DATA_W-1:0]  b_q [4];   // index {k, col}
  logic [DATA_W-1:0]  partial [4];
  logic               accept;
  logic               last;
  logic [1:0]         pidx;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] prod;
  logic [DATA_W-1:0]  acc_sum;
  logic [DATA_W-1:0]  res_11;
  logic [DATA_W-1:0]  res_12;
  logic [DATA_W-1:0]  res_21;
  logic [DATA_W-1:0]  res_22;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (cnt == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: accept = start;
      MUL: begin
        busy = 1'b1;
        last = (cnt == 3'd7);
      end
      default: ;
    endcase
  end

  // cnt = {row, col, k}: the product order walks k fastest, then col, then row.
  assign pidx = cnt[2:1];
  assign op_a = a_q[{cnt[2], cnt[0]}];
  assign op_b = b_q[{cnt[0], cnt[1]}];
  // Only the low DATA_W bits of the signed product are kept, so it is sized at DATA_W.
  assign prod    = op_a * op_b;
  assign acc_sum = partial[pidx] + prod;

`ifdef BLOCK_MAC_ACCUM_EN
  logic acc_clr_q;
  always_comb begin
    res_11 = acc_clr_q ? partial[0] : c_11 + partial[0];
    res_12 = acc_clr_q ? partial[1] : c_12 + partial[1];
    res_21 = acc_clr_q ? partial[2] : c_21 + partial[2];
    res_22 = acc_clr_q ? acc_sum    : c_22 + acc_sum;
  end
  always_ff @(posedge clk) begin
    if (rst)         acc_clr_q <= 1'b0;
    else if (accept) acc_clr_q <= acc_clr;
  end
`else
  always_comb begin
    res_11 = partial[0];
    res_12 = partial[1];
    res_21 = partial[2];
    res_22 = acc_sum;
  end
`endif

  // Datapath: operand capture, partial sums and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 3'd0;
      done <= 1'b0;
      c_11 <= '0;
      c_12 <= '0;
      c_21 <= '0;
      c_22 <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        partial[i] <= '0;
      end
    end else begin
      done <= last;
      if (accept) begin
        cnt    <= 3'd0;
        a_q[0] <= a_11;
        a_q[1] <= a_12;
        a_q[2] <= a_21;
        a_q[3] <= a_22;
        b_q[0] <= b_11;
        b_q[1] <= b_12;
        b_q[2] <= b_21;
        b_q[3] <= b_22;
      end else if (state == MUL) begin
        cnt <= cnt + 3'd1;
        partial[pidx] <= cnt[0] ? acc_sum : prod;
        // c_22's last product is still in flight here, so it takes acc_sum directly.
        if (last) begin
          c_11 <= res_11;
          c_12 <= res_12;
          c_21 <= res_21;
          c_22 <= res_22;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_mac_2x2.sv
// Self-checking bench for block_mac_2x2: directed and random 2x2 products against a matrix model.
module tb_block_mac_2x2;

`ifdef BLOCK_MAC_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        acc_clr_v;
  logic [31:0] av [4];   // a11 a12 a21 a22
  logic [31:0] bv [4];   // b11 b12 b21 b22
  logic [31:0] c11, c12, c21, c22;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] snap_a [4];
  logic [31:0] snap_b [4];
  logic [31:0] mc      [4];
  logic [31:0] mc_prev [4];

  block_mac_2x2 #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef BLOCK_MAC_ACCUM_EN
    .acc_clr (acc_clr_v),
`endif
    .a_11 (av[0]), .a_12 (av[1]), .a_21 (av[2]), .a_22 (av[3]),
    .b_11 (bv[0]), .b_12 (bv[1]), .b_21 (bv[2]), .b_22 (bv[3]),
    .c_11 (c11),   .c_12 (c12),   .c_21 (c21),   .c_22 (c22),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [31:0] e11, input logic [31:0] e12,
                       input logic [31:0] e21, input logic [31:0] e22);
    chk({tag, "_c11"}, c11, e11);
    chk({tag, "_c12"}, c12, e12);
    chk({tag, "_c21"}, c21, e21);
    chk({tag, "_c22"}, c22, e22);
  endtask

  // Plain matrix product of the snapshot, modulo 2^32, folded into the model result.
  task automatic model_compute(input bit clr);
    logic [31:0] s;
    mc_prev = mc;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 32'd0;
        for (int k = 0; k < 2; k++) s = s + snap_a[i*2+k] * snap_b[k*2+j];
        mc[i*2+j] = (ACC && !clr) ? mc[i*2+j] + s : s;
      end
  endtask

  task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3);
    av[0] = a0; av[1] = a1; av[2] = a2; av[3] = a3;
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
  endtask

  task automatic scramble_ops();
    for (int i = 0; i < 4; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
    end
  endtask

  // One operation: start pulse, a stray start mid-run, operands scrambled during MUL.
  task automatic do_op(input string tag, input bit clr);
    @(negedge clk);
    start = 1'b1; acc_clr_v = clr;
    snap_a = av; snap_b = bv;
    model_compute(clr);
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      start = (k == 3); acc_clr_v = ~clr;
      scramble_ops();
      @(posedge clk); #1;
      chk({tag, "_busy_mid"}, busy, 1);
      chk({tag, "_done_mid"}, done, 0);
      chk_c({tag, "_hold"}, mc_prev[0], mc_prev[1], mc_prev[2], mc_prev[3]);
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_e8"}, done, 1);
    chk({tag, "_busy_e8"}, busy, 0);
    chk_c({tag, "_res"}, mc[0], mc[1], mc[2], mc[3]);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, done, 0);
    chk_c({tag, "_keep"}, mc[0], mc[1], mc[2], mc[3]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_clr_v = 1'b1;
    scramble_ops();
    for (int i = 0; i < 4; i++) mc[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_c("rst", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;

    // Basic product
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    do_op("basic", 1'b1);
    chk_c("basic_const", 19, 22, 43, 50);

    // Signed operands
    set_ops(-1, 0, 0, -1, 3, 4, 5, 6);
    do_op("signed", 1'b1);
    chk_c("signed_const", 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'hFFFFFFFA);

    // Wrap-around of product
    set_ops(32'h00010000, 0, 0, 0, 32'h00010000, 0, 0, 0);
    do_op("wrap", 1'b1);
    chk_c("wrap_const", 0, 0, 0, 0);

    // Random operands
    for (int r = 0; r < 4; r++) begin
      scramble_ops();
      do_op("rand", 1'b1);
    end

    // Back-to-back with start held high and operands changing each cycle
    for (int cyc = 0; cyc < 27; cyc++) begin
      @(negedge clk);
      start = 1'b1; acc_clr_v = 1'b1;
      scramble_ops();
      if (cyc % 9 == 0) begin
        snap_a = av; snap_b = bv;
        model_compute(1'b1);
      end
      @(posedge clk); #1;
      chk("b2b_done", done, (cyc % 9 == 8) ? 1 : 0);
      if (cyc % 9 == 8) chk_c("b2b_res", mc[0], mc[1], mc[2], mc[3]);
      else              chk_c("b2b_hold", mc_prev[0], mc_prev[1], mc_prev[2], mc_prev[3]);
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", busy, 0);

    // Reset abort four cycles into an operation
    @(negedge clk);
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk_c("abort", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) mc[i] = 32'd0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("abort_nodone", done, 0);
    end
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    do_op("after_abort", 1'b1);
    chk_c("after_abort_const", 19, 22, 43, 50);

    if (ACC) begin
      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      do_op("acc_clr", 1'b1);
      chk_c("acc_clr_const", 19, 22, 43, 50);
      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      do_op("acc_add", 1'b0);
      chk_c("acc_add_const", 38, 44, 86, 100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
